elastic_pipe_stage: RTL and testbench
=====================================

ELASTIC_PIPE_STAGE -- requirements
Module: elastic_pipe_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, stage payload width in bits (legal 1..256).
REQ-002 SHALL provide parameter NOP_VAL, default '0 (DATA_W bits), payload loaded on reset/flush (bubble encoding).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept; transfer = in_valid & in_ready at a rising edge.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port flush  input  1  synchronous kill of all held payloads.
REQ-010 SHALL have port out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-012 SHALL have port out_data  output  DATA_W  downstream payload (head entry).
REQ-013 SHALL have port occupancy  output  2  entries held (0,1,2).
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of both counters.
REQ-015 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid & !out_ready.
REQ-016 SHALL have port bubble_cnt  output  CNT_W  cycles with !out_valid & out_ready.

Function
REQ-017 SHALL hold payloads in a 2-entry skid buffer: head register (drives out_data) and skid register; states EMPTY, HALF, FULL.
REQ-018 SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), occupancy = 0/1/2 for EMPTY/HALF/FULL, all decoded from registered state only (no in->out combinational path).
REQ-019 SHALL transition EMPTY: push -> HALF, head <= in_data; otherwise stay.
REQ-020 SHALL transition HALF: push & !pop -> FULL, skid <= in_data; pop & !push -> EMPTY; push & pop -> HALF, head <= in_data; neither -> stay.
REQ-021 SHALL transition FULL: pop -> HALF, head <= skid; !pop -> stay (no push possible).
REQ-022 SHALL give latency of exactly 1 cycle from push to out_valid when empty, and sustain one transfer per cycle with out_ready held high.
REQ-023 SHALL keep out_data and out_valid stable while out_valid & !out_ready, and preserve strict FIFO order.
REQ-024 SHALL, on flush, go to EMPTY and load head and skid with NOP_VAL next cycle, discarding any same-cycle push; a same-cycle pop still counts as a completed transfer.
REQ-025 SHALL drive out_data = NOP_VAL whenever state is EMPTY.
REQ-026 SHALL increment stall_cnt and bubble_cnt per REQ-015/016 using pre-edge (pre-flush) values, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL give cnt_clr priority over increment: counter = 0 next cycle.

Reset
REQ-028 SHALL, while RST is high, force state EMPTY, head = skid = NOP_VAL, counters 0; outputs therefore in_ready=1, out_valid=0, occupancy=0, out_data=NOP_VAL.
REQ-029 SHALL ignore in_valid/out_ready during RST; first transfer is possible on the first rising edge after RST falls.
REQ-030 SHALL, on RST mid-operation, drop all held payloads immediately (asynchronously).

Structure
REQ-031 SHALL place typedef enum stage_state_t {EMPTY, HALF, FULL} and default CNT_W constant in shared package pipe_types_pkg.
REQ-032 SHALL implement counters via one sub-module sat_counter (param W; inputs inc, clr; async active-high reset), instantiated twice.

Verification
REQ-033 Stream: out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on cycles 1,2,3, occupancy never 2, stall_cnt=0.
REQ-034 Backpressure: out_ready=0, push 0xA1,0xA2 -> occupancy 2, in_ready=0, out_data=0xA1 held; raise out_ready 3 cycles later -> 0xA1 then 0xA2 out, stall_cnt=5 at the end of the sequence (cycles with out_valid & !out_ready: 0xA1 held 5 cycles).
REQ-035 Flush in FULL with in_valid=1: next cycle occupancy=0, out_valid=0, out_data=NOP_VAL, pushed word never appears.
REQ-036 Saturation: CNT_W=4, out_ready=1 with stage empty for 20 cycles -> bubble_cnt=15; assert cnt_clr with increment active -> 0.
REQ-037 Async reset: assert RST between edges while FULL -> out_valid=0, occupancy=0 before next edge; release, push 0x5 -> out_valid one cycle later with 0x5.
REQ-038 Random valid/ready (10k cycles, DATA_W=8): scoreboard shows no loss, duplication or reorder; in_ready never 1 when occupancy=2.

Source files
------------

// File: rtl/pipe_types_pkg.sv
// Shared types and constants for the elastic pipeline stage.
// Holds the stage state encoding, the default counter width and an occupancy decoder.
package pipe_types_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned OCC_W     = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Number of entries held in a given state
  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t s);
    case (s)
      HALF:    occ_of = OCC_W'(1);
      FULL:    occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipe_stage_if.sv
// Handshake, payload, flush and counter signals of the elastic pipeline stage.
// The master side feeds the stage; the slave side is the stage itself.
interface elastic_pipe_stage_if
  import pipe_types_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt, bubble_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, occupancy, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/elastic_pipe_stage.sv
// Two-entry skid-buffer pipeline stage with flush and stall/bubble performance counters.
// All handshake outputs come straight from flops, so there is no in->out combinational path.
module elastic_pipe_stage
  import pipe_types_pkg::*;
#(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  elastic_pipe_stage_if.slave  bus
);

  stage_state_t      state, state_nxt;
  logic [DATA_W-1:0] head, head_nxt;
  logic [DATA_W-1:0] skid, skid_nxt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [OCC_W-1:0]  occ_q;
  logic              push, pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // State and payload registers; handshake flags are pre-decoded from the next state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= EMPTY;
      head        <= NOP_VAL;
      skid        <= NOP_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state       <= state_nxt;
      head        <= head_nxt;
      skid        <= skid_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      occ_q       <= occ_of(state_nxt);
    end
  end

  // Next-state and payload movement; head returns to the bubble value whenever the stage drains
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (bus.flush) begin
      state_nxt = EMPTY;
      head_nxt  = NOP_VAL;
      skid_nxt  = NOP_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = HALF;
            head_nxt  = bus.in_data;
          end
        end
        HALF: begin
          if (push && !pop) begin
            state_nxt = FULL;
            skid_nxt  = bus.in_data;
          end else if (pop && !push) begin
            state_nxt = EMPTY;
            head_nxt  = NOP_VAL;
          end else if (push && pop) begin
            head_nxt  = bus.in_data;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = HALF;
            head_nxt  = skid;
          end
        end
        default: begin
          state_nxt = EMPTY;
          head_nxt  = NOP_VAL;
          skid_nxt  = NOP_VAL;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head;
  assign bus.occupancy = occ_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (out_valid_q & ~bus.out_ready),
    .clr   (bus.cnt_clr),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (~out_valid_q & bus.out_ready),
    .clr   (bus.cnt_clr),
    .count (bus.bubble_cnt)
  );

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed and scoreboard-checked stimulus for elastic_pipe_stage (DATA_W=8, CNT_W=4, NOP=0xEE).
module tb_elastic_pipe_stage;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;
  localparam logic [DW-1:0] NOP = 8'hEE;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [DW-1:0] sb[$];

  elastic_pipe_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  elastic_pipe_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  task automatic clr_cnt(input logic rdy);
    set_in(1'b0, 8'h00, rdy);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    chk("clr_stall", 32'(bus.stall_cnt), 32'd0);
    chk("clr_bubble", 32'(bus.bubble_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.cnt_clr = 1'b0;
    set_in(1'b1, 8'h77, 1'b1);
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'(NOP));
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("rst_bubble", 32'(bus.bubble_cnt), 32'd0);
    set_in(1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Streaming at full rate
    clr_cnt(1'b1);
    set_in(1'b1, 8'h11, 1'b1); tick();
    chk("str_v1", 32'(bus.out_valid), 32'd1);
    chk("str_d1", 32'(bus.out_data), 32'h11);
    chk("str_o1", 32'(bus.occupancy), 32'd1);
    set_in(1'b1, 8'h22, 1'b1); tick();
    chk("str_d2", 32'(bus.out_data), 32'h22);
    chk("str_o2", 32'(bus.occupancy), 32'd1);
    set_in(1'b1, 8'h33, 1'b1); tick();
    chk("str_d3", 32'(bus.out_data), 32'h33);
    chk("str_o3", 32'(bus.occupancy), 32'd1);
    set_in(1'b0, 8'h00, 1'b1); tick();
    chk("str_drain_v", 32'(bus.out_valid), 32'd0);
    chk("str_drain_d", 32'(bus.out_data), 32'(NOP));
    chk("str_stall", 32'(bus.stall_cnt), 32'd0);
    chk("str_bubble", 32'(bus.bubble_cnt), 32'd1);

    // Backpressure into FULL, then drain
    clr_cnt(1'b0);
    set_in(1'b1, 8'hA1, 1'b0); tick();
    chk("bp_o1", 32'(bus.occupancy), 32'd1);
    set_in(1'b1, 8'hA2, 1'b0); tick();
    chk("bp_full_occ", 32'(bus.occupancy), 32'd2);
    chk("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_full_d", 32'(bus.out_data), 32'hA1);
    set_in(1'b1, 8'hA3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_d", 32'(bus.out_data), 32'hA1);
      chk("bp_hold_v", 32'(bus.out_valid), 32'd1);
    end
    chk("bp_stall_mid", 32'(bus.stall_cnt), 32'd5);
    set_in(1'b0, 8'h00, 1'b1); tick();
    chk("bp_pop1_d", 32'(bus.out_data), 32'hA2);
    chk("bp_pop1_o", 32'(bus.occupancy), 32'd1);
    tick();
    chk("bp_pop2_v", 32'(bus.out_valid), 32'd0);
    chk("bp_pop2_d", 32'(bus.out_data), 32'(NOP));
    chk("bp_stall_end", 32'(bus.stall_cnt), 32'd5);

    // Flush while FULL with a pending push
    set_in(1'b1, 8'hB1, 1'b0); tick();
    set_in(1'b1, 8'hB2, 1'b0); tick();
    chk("fl_pre_occ", 32'(bus.occupancy), 32'd2);
    set_in(1'b1, 8'hB3, 1'b0);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("fl_occ", 32'(bus.occupancy), 32'd0);
    chk("fl_v", 32'(bus.out_valid), 32'd0);
    chk("fl_d", 32'(bus.out_data), 32'(NOP));
    chk("fl_rdy", 32'(bus.in_ready), 32'd1);
    set_in(1'b0, 8'h00, 1'b1); tick();
    chk("fl_no_b3", 32'(bus.out_valid), 32'd0);

    // Flush in HALF discards an accepted same-cycle push
    set_in(1'b1, 8'hC1, 1'b0); tick();
    set_in(1'b1, 8'hC2, 1'b0);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("flh_occ", 32'(bus.occupancy), 32'd0);
    set_in(1'b0, 8'h00, 1'b1); tick();
    chk("flh_no_c2", 32'(bus.out_valid), 32'd0);

    // Bubble counter saturation and clear-over-increment
    clr_cnt(1'b1);
    set_in(1'b0, 8'h00, 1'b1);
    repeat (20) tick();
    chk("sat_bubble", 32'(bus.bubble_cnt), 32'd15);
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    chk("sat_clr", 32'(bus.bubble_cnt), 32'd0);

    // Asynchronous reset between edges while FULL
    set_in(1'b1, 8'hD1, 1'b0); tick();
    set_in(1'b1, 8'hD2, 1'b0); tick();
    chk("ar_pre_occ", 32'(bus.occupancy), 32'd2);
    set_in(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_v", 32'(bus.out_valid), 32'd0);
    chk("ar_occ", 32'(bus.occupancy), 32'd0);
    chk("ar_d", 32'(bus.out_data), 32'(NOP));
    #1 rst = 1'b0;
    set_in(1'b1, 8'h05, 1'b0); tick();
    chk("ar_first_v", 32'(bus.out_valid), 32'd1);
    chk("ar_first_d", 32'(bus.out_data), 32'h05);
    set_in(1'b0, 8'h00, 1'b1); tick();
    chk("ar_drain", 32'(bus.out_valid), 32'd0);

    // Random valid/ready against a FIFO scoreboard
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      logic push, pop;
      set_in(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      push = bus.in_valid & bus.in_ready;
      pop  = bus.out_valid & bus.out_ready;
      if (pop) begin
        if (sb.size() == 0) chk("rnd_pop_empty", 32'd1, 32'd0);
        else chk("rnd_order", 32'(bus.out_data), 32'(sb.pop_front()));
      end
      if (push) sb.push_back(bus.in_data);
      tick();
      chk("rnd_occ", 32'(bus.occupancy), 32'(sb.size()));
      chk("rnd_rdy", 32'(bus.in_ready), 32'(sb.size() < 2));
    end
    set_in(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) chk("rnd_dup", 32'd1, 32'd0);
        else chk("rnd_drain_order", 32'(bus.out_data), 32'(sb.pop_front()));
      end
      tick();
    end
    chk("rnd_left", 32'(sb.size()), 32'd0);
    chk("rnd_final_occ", 32'(bus.occupancy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
